obuf_result_reader: RTL
=======================

# obuf_result_reader

Read-side engine for the systolic output buffer. After an OS drain has written a result tile into the per-column o_buf RAMs, this block walks `o_ram_idx`/`o_read_addr` over the tile and captures the returned 32-bit words. It streams them out over a valid/ready interface with destination addresses toward BRAM. It replaces bench-driven readback loops and sits between `systolic_system` and the BRAM writer.

## Interface
- `ARRAY_M`, 16, columns / number of o_buf RAMs
- `ARRAY_N`, 16, rows per tile (max)
- `DATA_WIDTH`, 32, result word width (signed two's complement)
- `ADDR_WIDTH`, 10, o_buf address width
- `DST_ADDR_WIDTH`, 16, destination address width

Ports:
- `clk` in 1: single clock
- `reset` in 1: synchronous, active-high
- `start` in 1: one-cycle command pulse, sampled in IDLE only
- `o_base_addr` in ADDR_WIDTH: first o_buf row address
- `num_rows` in $clog2(ARRAY_N)+1: tile rows R
- `num_cols` in $clog2(ARRAY_M)+1: tile columns C
- `dst_base` in DST_ADDR_WIDTH: destination base address
- `dst_stride` in DST_ADDR_WIDTH: destination row pitch
- `o_ram_idx` out $clog2(ARRAY_M): o_buf RAM select
- `o_read_addr` out ADDR_WIDTH: o_buf read address
- `o_rd_data` in DATA_WIDTH: o_buf read data, valid 1 cycle after address
- `out_valid` out 1, `out_ready` in 1: result stream handshake
- `out_data` out DATA_WIDTH, `out_addr` out DST_ADDR_WIDTH: beat payload
- `busy` out 1, `done` out 1: status; done is a one-cycle pulse

## Operation
- `start` latches all command inputs. C > ARRAY_M clamps to ARRAY_M; R > ARRAY_N clamps to ARRAY_N.
- Scan order: outer col c = 0..C-1 (`o_ram_idx`=c), inner row r = 0..R-1 (`o_read_addr`=o_base_addr+r, modulo 2^ADDR_WIDTH).
- `out_addr` = dst_base + r*dst_stride + c, truncated to DST_ADDR_WIDTH. The row term is accumulated incrementally (no multiplier).
- States:
  - IDLE: on `start`, go to READ, or go to DONE if R==0 or C==0.
  - READ: issue reads; after the last read issues, go to DRAIN.
  - DRAIN: when in-flight = 0 and FIFO is empty, go to DONE.
  - DONE: single cycle, then IDLE.
- Output buffering: 2-entry FIFO.
  - Issue a read only if occupancy + inflight − pop < 2, where pop = out_valid & out_ready.
  - Nothing is ever dropped or duplicated under backpressure.
- `out_data`/`out_addr` must hold stable while out_valid=1 and out_ready=0.
- `start` while busy is ignored.
- `reset` at any time forces IDLE, empties the FIFO, and cancels the in-flight read; the returning o_rd_data is discarded.
- Reset values:
  - out_valid=0, busy=0, done=0
  - o_ram_idx=0, o_read_addr=0
  - out_data=0, out_addr=0

## Timing
- `start` sampled at edge E0. First address driven in cycle 1, data on o_rd_data in cycle 2, written into the FIFO at the end of cycle 2, out_valid=1 in cycle 3.
- With out_ready held high: one beat per cycle, last beat in cycle 2+R·C, done in cycle 3+R·C, busy low in the cycle after done.
- busy=1 from cycle 1 through the done cycle inclusive.
- Zero-size tile: done in cycle 1, no reads, no beats.
- o_ram_idx/o_read_addr hold their last value when no read is issued.

## Configuration
- `OBUF_RD_RELU_EN` defined: out_data = (word < 0) ? 0 : word, applied on FIFO write.
- Undefined: words pass unchanged.
- Addresses and timing are identical in both builds.

## Structure
- Shared package `systolic_pkg`:
  - state enum (IDLE/READ/DRAIN/DONE)
  - FIFO depth constant (2)
  - width localparams derived from ARRAY_M/ARRAY_N
- One sub-module: `obuf_rd_fifo`, a 2-entry valid/ready FIFO with occupancy output.
- Scan counters, address accumulator and FSM live in the top.

## Test plan
- R=3, C=2, base=5, dst_base=0x100, stride=8, ready=1, o_buf word = {c,r} pattern:
  - 6 beats in order (c0r0..c0r2, c1r0..c1r2)
  - addrs 0x100,0x108,0x110,0x101,0x109,0x111
  - first valid in cycle 3, done in cycle 9
- Same tile, out_ready toggling 1/0 and random stalls of 5 cycles:
  - identical 6-beat sequence
  - payload stable while stalled
  - FIFO occupancy never exceeds 2
- C=0 (then separately R=0): done in cycle 1, out_valid never asserted, o_buf address lines never change.
- base=0x3FE, R=4: o_read_addr sequence 0x3FE,0x3FF,0x000,0x001.
- Reset asserted in cycle 4 of a 16×16 readback, then a new start with R=1, C=1:
  - outputs at reset values the cycle after reset
  - only the single new beat appears
- Word 0xFFFFFFF0: out_data=0 with `OBUF_RD_RELU_EN`, 0xFFFFFFF0 without; 0x00000010 passes in both builds.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic output-buffer read path: default array
// geometry, derived widths, read-engine states and result FIFO depth.
package systolic_pkg;

   localparam int SYS_ARRAY_M = 16;
   localparam int SYS_ARRAY_N = 16;
   localparam int SYS_IDX_W   = $clog2(SYS_ARRAY_M);
   localparam int SYS_ROW_W   = $clog2(SYS_ARRAY_N);
   localparam int SYS_RN_W    = SYS_ROW_W + 1;
   localparam int SYS_CN_W    = SYS_IDX_W + 1;

   localparam int FIFO_DEPTH  = 2;
   localparam int OCC_W       = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } rd_state_t;

endpackage

// File: rtl/obuf_rd_fifo.sv
// Two-entry valid/ready FIFO holding result beats; storage clears on reset so
// the head reads as zero until the first write.
module obuf_rd_fifo
   import systolic_pkg::*;
#(
   parameter int WIDTH = 48
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [OCC_W-1:0] occupancy
);

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic             wr_ptr;
   logic             rd_ptr;
   logic             push;
   logic             pop;

   assign in_ready  = (occupancy < OCC_W'(FIFO_DEPTH));
   assign out_valid = (occupancy != '0);
   assign out_data  = mem[rd_ptr];
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         occupancy <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   occupancy <= occupancy + OCC_W'(1);
            2'b01:   occupancy <= occupancy - OCC_W'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

endmodule

// File: rtl/obuf_result_reader.sv
// Walks o_buf column by column over a result tile and streams each word with its
// destination address. Define OBUF_RD_RELU_EN to clamp negative words to zero.
module obuf_result_reader
   import systolic_pkg::*;
#(
   parameter int ARRAY_M        = SYS_ARRAY_M,
   parameter int ARRAY_N        = SYS_ARRAY_N,
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 10,
   parameter int DST_ADDR_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [ADDR_WIDTH-1:0]       o_base_addr,
   input  logic [$clog2(ARRAY_N):0]    num_rows,
   input  logic [$clog2(ARRAY_M):0]    num_cols,
   input  logic [DST_ADDR_WIDTH-1:0]   dst_base,
   input  logic [DST_ADDR_WIDTH-1:0]   dst_stride,
   output logic [$clog2(ARRAY_M)-1:0]  o_ram_idx,
   output logic [ADDR_WIDTH-1:0]       o_read_addr,
   input  logic [DATA_WIDTH-1:0]       o_rd_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_WIDTH-1:0]       out_data,
   output logic [DST_ADDR_WIDTH-1:0]   out_addr,
   output logic                        busy,
   output logic                        done
);

   localparam int IDX_W  = $clog2(ARRAY_M);
   localparam int ROW_W  = $clog2(ARRAY_N);
   localparam int RN_W   = ROW_W + 1;
   localparam int CN_W   = IDX_W + 1;
   localparam int BEAT_W = DATA_WIDTH + DST_ADDR_WIDTH;

   rd_state_t                 state;
   rd_state_t                 state_nxt;

   logic [RN_W-1:0]           rows_q;
   logic [CN_W-1:0]           cols_q;
   logic [ADDR_WIDTH-1:0]     base_q;
   logic [DST_ADDR_WIDTH-1:0] dst_base_q;
   logic [DST_ADDR_WIDTH-1:0] stride_q;
   logic [DST_ADDR_WIDTH-1:0] row_acc;
   logic [ROW_W-1:0]          row_cnt;

   logic                      inflight;
   logic [DST_ADDR_WIDTH-1:0] inflight_dst;

   logic [RN_W-1:0]           rows_clamped;
   logic [CN_W-1:0]           cols_clamped;
   logic                      zero_tile;
   logic                      row_last;
   logic                      col_last;
   logic                      issue;
   logic                      pop;
   logic [OCC_W:0]            credit;
   logic [OCC_W:0]            limit;
   logic [DST_ADDR_WIDTH-1:0] issue_dst;

   logic [DATA_WIDTH-1:0]     wr_word;
   logic                      fifo_in_ready;
   logic [BEAT_W-1:0]         fifo_out;
   logic [OCC_W-1:0]          occupancy;

   assign rows_clamped = (num_rows > RN_W'(ARRAY_N)) ? RN_W'(ARRAY_N) : num_rows;
   assign cols_clamped = (num_cols > CN_W'(ARRAY_M)) ? CN_W'(ARRAY_M) : num_cols;
   assign zero_tile    = (rows_clamped == '0) || (cols_clamped == '0);

   assign row_last  = ({1'b0, row_cnt} == rows_q - RN_W'(1));
   assign col_last  = ({1'b0, o_ram_idx} == cols_q - CN_W'(1));
   assign issue_dst = dst_base_q + row_acc + DST_ADDR_WIDTH'(o_ram_idx);

   // A read may only issue if its word is guaranteed a FIFO slot on return,
   // counting the beat leaving this cycle.
   assign pop    = out_valid & out_ready;
   assign credit = {1'b0, occupancy} + {{OCC_W{1'b0}}, inflight};
   assign limit  = (OCC_W + 1)'(FIFO_DEPTH) + {{OCC_W{1'b0}}, pop};
   assign issue  = (state == ST_READ) && (credit < limit);

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = zero_tile ? ST_DONE : ST_READ;
            end
         end
         ST_READ: begin
            if (issue && row_last && col_last) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Leave as soon as the FIFO will be empty after this cycle's pop.
            if (!inflight && (occupancy == {{(OCC_W-1){1'b0}}, pop})) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         rows_q       <= '0;
         cols_q       <= '0;
         base_q       <= '0;
         dst_base_q   <= '0;
         stride_q     <= '0;
         row_acc      <= '0;
         row_cnt      <= '0;
         o_ram_idx    <= '0;
         o_read_addr  <= '0;
         inflight     <= 1'b0;
         inflight_dst <= '0;
      end else begin
         state    <= state_nxt;
         inflight <= issue;
         if (issue) begin
            inflight_dst <= issue_dst;
         end
         if ((state == ST_IDLE) && start) begin
            rows_q     <= rows_clamped;
            cols_q     <= cols_clamped;
            base_q     <= o_base_addr;
            dst_base_q <= dst_base;
            stride_q   <= dst_stride;
            if (!zero_tile) begin
               o_ram_idx   <= '0;
               o_read_addr <= o_base_addr;
               row_cnt     <= '0;
               row_acc     <= '0;
            end
         end else if (issue && !(row_last && col_last)) begin
            if (row_last) begin
               row_cnt     <= '0;
               row_acc     <= '0;
               o_read_addr <= base_q;
               o_ram_idx   <= o_ram_idx + IDX_W'(1);
            end else begin
               row_cnt     <= row_cnt + ROW_W'(1);
               row_acc     <= row_acc + stride_q;
               o_read_addr <= o_read_addr + ADDR_WIDTH'(1);
            end
         end
      end
   end

`ifdef OBUF_RD_RELU_EN
   assign wr_word = o_rd_data[DATA_WIDTH-1] ? '0 : o_rd_data;
`else
   assign wr_word = o_rd_data;
`endif

   obuf_rd_fifo #(
      .WIDTH(BEAT_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (inflight & fifo_in_ready),
      .in_ready  (fifo_in_ready),
      .in_data   ({wr_word, inflight_dst}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (fifo_out),
      .occupancy (occupancy)
   );

   assign out_data = fifo_out[BEAT_W-1 -: DATA_WIDTH];
   assign out_addr = fifo_out[DST_ADDR_WIDTH-1:0];

endmodule
